// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALUOp classes, ALUControl codes and datapath mux selects.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } mcu_state_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_R   = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:     imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_dec.sv
// Combinational ALU decoder: ALUOp class plus instruction fields to ALUControl,
// with the 3-bit operation code zero-extended to ALUCTRL_W.
module multicycle_alu_dec
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  alu_op_e                alu_op_i,
    input  logic [2:0]             funct3_i,
    input  logic                   funct7b5_i,
    input  logic                   opb5_i,
    output logic [ALUCTRL_W-1:0]   alu_control_o
);

    logic [2:0] code;

    always_comb begin
        code = ALUC_ADD;
        case (alu_op_i)
            ALUOP_ADD: code = ALUC_ADD;
            ALUOP_SUB: code = ALUC_SUB;
            ALUOP_R: begin
                case (funct3_i)
                    // Only register-register ops with funct7[5] subtract; addi keeps add.
                    3'b000:  code = (opb5_i && funct7b5_i) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  code = ALUC_SLT;
                    3'b110:  code = ALUC_OR;
                    3'b111:  code = ALUC_AND;
                    default: code = ALUC_ADD;
                endcase
            end
            default: code = ALUC_ADD;
        endcase
    end

    assign alu_control_o = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions over a shared-memory multicycle datapath,
// with a memory ready handshake, optional bne and illegal-opcode reporting.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned ALUCTRL_W     = 3,
    parameter bit          USE_MEM_READY = 1'b1,
    parameter bit          ENABLE_BNE    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  reg_write,
    output logic [1:0]            imm_src,
    output logic [ALUCTRL_W-1:0]  alu_control,
    output logic                  illegal_instr,
    output logic                  instr_done
);

    mcu_state_e state_q, state_d;
    alu_op_e    alu_op;
    logic       rdy;
    logic       bne_sel;
    logic       unused_funct7;

    assign rdy           = USE_MEM_READY ? mem_ready : 1'b1;
    assign bne_sel       = ENABLE_BNE && (funct3 == 3'b001);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (rdy) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        reg_write     = 1'b0;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = rdy;
                pc_write   = rdy;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                // Unsupported opcodes retire here with no side effects.
                if (!(op inside {OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL})) begin
                    illegal_instr = 1'b1;
                    instr_done    = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                mem_write  = rdy;
                instr_done = rdy;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_R;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_R;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                pc_write   = zero ^ bne_sel;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign imm_src = imm_src_of(op);

    multicycle_alu_dec #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7[5]),
        .opb5_i        (op[5]),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each instruction is expanded into its expected sequence of phases,
// per-cycle expected outputs are queued and a monitor compares them on the falling edge.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr, instr_done;

    multicycle_control_unit #(
        .ALUCTRL_W     (3),
        .USE_MEM_READY (1'b1),
        .ENABLE_BNE    (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    always #5 clk = ~clk;

    // Phases of an instruction as described by the control-unit behaviour.
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_XR = 6, P_XI = 7, P_AWB = 8, P_BR = 9, P_JAL = 10;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done_seen = 0;
    int          n_done_exp = 0;
    int          cyc_no = 0;

    function automatic string ph_name(input int ph);
        string s;
        case (ph)
            P_F: s = "fetch";    P_D: s = "decode";  P_MA: s = "memadr";
            P_MR: s = "memread"; P_MWB: s = "memwb"; P_MW: s = "memwrite";
            P_XR: s = "execr";   P_XI: s = "execi";  P_AWB: s = "aluwb";
            P_BR: s = "branch";  P_JAL: s = "jal";   default: s = "?";
        endcase
        return s;
    endfunction

    function automatic bit legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
    endfunction

    function automatic logic [2:0] rdec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        logic [2:0] r;
        if (f3 == 3'b000)      r = (o[5] && f7[5]) ? 3'd1 : 3'd0;
        else if (f3 == 3'b010) r = 3'd5;
        else if (f3 == 3'b110) r = 3'd3;
        else if (f3 == 3'b111) r = 3'd2;
        else                   r = 3'd0;
        return r;
    endfunction

    // Expected output vector for one cycle, packed in the monitor's field order.
    function automatic logic [18:0] expect_out(input int ph, input logic [6:0] o, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic z, input logic r);
        logic mreq, pcw, adr, mw, irw, rw, ill, done;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
        {mreq, pcw, adr, mw, irw, rw, ill, done} = 8'd0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
        imm = (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        case (ph)
            P_F:   begin mreq = 1; sb = 2'd2; res = 2'd2; irw = r; pcw = r; end
            P_D:   begin sa = 2'd1; sb = 2'd1; ill = !legal(o); done = !legal(o); end
            P_MA:  begin sa = 2'd2; sb = 2'd1; end
            P_MR:  begin mreq = 1; adr = 1; end
            P_MWB: begin res = 2'd1; rw = 1; done = 1; end
            P_MW:  begin mreq = 1; adr = 1; mw = r; done = r; end
            P_XR:  begin sa = 2'd2; sb = 2'd0; alu = rdec(o, f3, f7); end
            P_XI:  begin sa = 2'd2; sb = 2'd1; alu = rdec(o, f3, f7); end
            P_AWB: begin rw = 1; done = 1; end
            P_BR:  begin sa = 2'd2; alu = 3'd1; pcw = z ^ (f3 == 3'b001); done = 1; end
            P_JAL: begin sa = 2'd1; sb = 2'd2; pcw = 1; end
            default: ;
        endcase
        return {mreq, pcw, adr, mw, irw, res, sa, sb, rw, imm, alu, ill, done};
    endfunction

    // One clock cycle of stimulus: drive inputs, queue the expectation, advance.
    task automatic cyc(input int ph, input logic rdy_v, input logic z, input logic rst_v);
        mem_ready = rdy_v;
        zero      = z;
        rst       = rst_v;
        exp_q.push_back(expect_out(ph, op, funct3, funct7, z, rdy_v));
        name_q.push_back($sformatf("%s@%0d", ph_name(ph), cyc_no));
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input int wf, input int wm, input logic zb);
        op = o; funct3 = f3; funct7 = f7;
        repeat (wf) cyc(P_F, 1'b0, 1'($urandom), 1'b0);
        cyc(P_F, 1'b1, 1'($urandom), 1'b0);
        cyc(P_D, 1'($urandom), 1'($urandom), 1'b0);
        case (o)
            LW: begin
                cyc(P_MA, 1'($urandom), 1'($urandom), 1'b0);
                repeat (wm) cyc(P_MR, 1'b0, 1'($urandom), 1'b0);
                cyc(P_MR, 1'b1, 1'($urandom), 1'b0);
                cyc(P_MWB, 1'($urandom), 1'($urandom), 1'b0);
            end
            SW: begin
                cyc(P_MA, 1'($urandom), 1'($urandom), 1'b0);
                repeat (wm) cyc(P_MW, 1'b0, 1'($urandom), 1'b0);
                cyc(P_MW, 1'b1, 1'($urandom), 1'b0);
            end
            RT: begin cyc(P_XR, 1'($urandom), 1'($urandom), 1'b0); cyc(P_AWB, 1'($urandom), 1'($urandom), 1'b0); end
            IT: begin cyc(P_XI, 1'($urandom), 1'($urandom), 1'b0); cyc(P_AWB, 1'($urandom), 1'($urandom), 1'b0); end
            BR: cyc(P_BR, 1'($urandom), zb, 1'b0);
            JL: begin cyc(P_JAL, 1'($urandom), 1'($urandom), 1'b0); cyc(P_AWB, 1'($urandom), 1'($urandom), 1'b0); end
            default: ;
        endcase
        n_done_exp++;
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs together.
    initial begin
        logic [18:0] e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {mem_req, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                      alu_src_b, reg_write, imm_src, alu_control, illegal_instr, instr_done};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: outputs got %b expected %b", nm, a, e);
                end
                if (instr_done === 1'b1) n_done_seen++;
            end
        end
    end

    initial begin
        logic [6:0] o, f7;
        logic [2:0] f3;
        int sel;
        // Reset held two edges; the cycle still under reset must show the fetch decode.
        op = LW;
        repeat (2) @(posedge clk);
        #1;
        cyc(P_F, 1'b0, 1'b0, 1'b1);

        run_instr(LW, 3'b010, 7'd0, 0, 0, 1'b0);
        run_instr(SW, 3'b010, 7'd0, 0, 2, 1'b0);
        run_instr(BR, 3'b000, 7'd0, 0, 0, 1'b1);
        run_instr(BR, 3'b000, 7'd0, 0, 0, 1'b0);
        run_instr(BR, 3'b001, 7'd0, 0, 0, 1'b0);
        run_instr(BR, 3'b001, 7'd0, 0, 0, 1'b1);
        run_instr(RT, 3'b000, 7'b0100000, 0, 0, 1'b0);
        run_instr(IT, 3'b000, 7'b0100000, 0, 0, 1'b0);
        run_instr(RT, 3'b111, 7'd0, 1, 0, 1'b0);
        run_instr(IT, 3'b110, 7'd0, 0, 0, 1'b0);
        run_instr(RT, 3'b010, 7'd0, 0, 0, 1'b0);
        run_instr(JL, 3'b000, 7'd0, 2, 0, 1'b0);
        run_instr(7'b1111111, 3'b000, 7'd0, 0, 0, 1'b0);

        // Reset while a load waits in memread: the bench then expects a fresh fetch.
        op = LW; funct3 = 3'b010; funct7 = 7'd0;
        cyc(P_F, 1'b1, 1'b0, 1'b0);
        cyc(P_D, 1'b0, 1'b0, 1'b0);
        cyc(P_MA, 1'b0, 1'b0, 1'b0);
        cyc(P_MR, 1'b0, 1'b0, 1'b0);
        cyc(P_MR, 1'b0, 1'b0, 1'b1);
        run_instr(SW, 3'b010, 7'd0, 0, 1, 1'b0);

        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 6));
            f3  = 3'($urandom);
            f7  = 7'($urandom);
            case (sel)
                0: o = LW; 1: o = SW; 2: o = RT; 3: o = IT; 4: o = BR; 5: o = JL;
                default: begin
                    o = 7'($urandom);
                    if (legal(o)) o = 7'b1111111;
                end
            endcase
            run_instr(o, f3, f7, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending expectations got %0d required 0", exp_q.size());
        end
        n_checks++;
        if (n_done_seen != n_done_exp) begin
            n_fail++;
            $display("FAIL done_count: instr_done pulses got %0d required %0d", n_done_seen, n_done_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control unit. A Moore FSM sequences each RV32I instruction over 3-5 cycles, plus memory wait cycles, on a shared-memory datapath.
- Sits between the instruction register (op/funct fields) and the multicycle datapath muxes, register file and unified memory.
- Adds a memory ready handshake, a parametrised ALU control width, optional bne support and illegal-opcode reporting.

Parameters:
ALUCTRL_W, 3, ALUControl width (>=3); codes zero-extended.
USE_MEM_READY, 1, 1 = honour mem_ready; 0 = memory treated as always ready.
ENABLE_BNE, 1, 1 = branch opcode with funct3=001 branches on !zero.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous active-high reset.
op  in  7  opcode from IR.
funct3  in  3  IR[14:12].
funct7  in  7  IR[31:25].
zero  in  1  ALU zero flag, sampled in S_BRANCH.
mem_ready  in  1  memory completes access this cycle.
mem_req  out  1  memory access in progress.
pc_write  out  1  PC register enable.
adr_src  out  1  0 = PC, 1 = ALU result register.
mem_write  out  1  store enable; qualified by mem_ready.
ir_write  out  1  IR/OldPC enable.
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register.
alu_src_b  out  2  00 rs2 register, 01 ImmExt, 10 constant 4.
reg_write  out  1  register file write enable.
imm_src  out  2  00 I, 01 S, 10 B, 11 J.
alu_control  out  ALUCTRL_W  ALU operation.
illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
instr_done  out  1  one-cycle pulse in the last state of each instruction.

Behaviour:
- States: S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL.
- rst=1 at an edge forces S_FETCH regardless of current state, including mid-access. No partial write completes after reset.
- All outputs are decoded from state, plus op/funct/zero/mem_ready. Unlisted outputs are 0. After reset, outputs equal the S_FETCH decode.
- imm_src is decoded combinationally from op in every state: lw/I-type = 00, sw = 01, branch = 10, jal = 11, else 00.
- S_FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ALUOp add, result_src=10.
  - ir_write and pc_write are asserted only when rdy (rdy = mem_ready, or 1 if USE_MEM_READY=0).
  - Stays in S_FETCH until rdy, then goes to S_DECODE.
- S_DECODE: alu_src_a=01, alu_src_b=01, add (branch target). Next state by op:
  - 0000011 / 0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BRANCH
  - 1101111 -> S_JAL
  - otherwise: pulse illegal_instr and instr_done, go to S_FETCH.
- S_MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to S_MEMREAD if op=lw, else S_MEMWRITE.
- S_MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until rdy, then S_MEMWB.
- S_MEMWB: result_src=01, reg_write=1, instr_done=1, then S_FETCH.
- S_MEMWRITE: mem_req=1, adr_src=1, result_src=00, mem_write=rdy, instr_done=rdy. Goes to S_FETCH on rdy.
- S_EXECR: alu_src_a=10, alu_src_b=00, ALUOp R. Then S_ALUWB.
- S_EXECI: alu_src_a=10, alu_src_b=01, ALUOp R. Then S_ALUWB.
- S_ALUWB: result_src=00, reg_write=1, instr_done=1, then S_FETCH.
- S_BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = zero XOR (ENABLE_BNE && funct3==001).
  - instr_done=1, then S_FETCH.
- S_JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Then S_ALUWB.
- ALU decode (ALUOp add / sub / R):
  - add = 000, sub = 001, and = 010, or = 011, slt = 101.
  - R with funct3=000: sub if op[5] && funct7[5], else add.
  - funct3=010 -> slt, 110 -> or, 111 -> and; other funct3 -> add.
- Latencies with no wait states: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles. Each memory wait cycle adds one cycle.
- mem_ready is ignored outside S_FETCH, S_MEMREAD and S_MEMWRITE.

Decomposition:
- Shared package: state enum, opcode constants, ALUOp encodings, ALUControl codes, result_src / src_a / src_b mux encodings.
- One sub-module, multicycle_alu_dec: combinational ALUOp + funct3 + funct7[5] + op[5] -> alu_control, parametrised by ALUCTRL_W.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset held 2 cycles, then lw (op=0000011), mem_ready=1 -> states F,D,MA,MR,WB. reg_write=1 only in cycle 5; instr_done pulse at cycle 5.
- sw with mem_ready low for 2 cycles in S_MEMWRITE -> mem_req=1 for 3 cycles, mem_write=1 only in the ready cycle, 6 cycles total.
- beq: zero=1 -> pc_write=1 in S_BRANCH. zero=0 -> pc_write=0. bne (funct3=001) with zero=0 -> pc_write=1.
- R-type: funct3=000, funct7=0100000 -> alu_control=001 in S_EXECR. I-type addi with funct7[5]=1 -> 000.
- op=1111111 -> illegal_instr pulse in S_DECODE, next state S_FETCH, no reg_write or mem_write.
- rst asserted in S_MEMREAD while waiting -> next cycle S_FETCH, reg_write never asserted.
